// File: rtl/memory_burst_control.sv
// Burst read/write sequencer for a synchronous single-port RAM.
// Commands use a request/ready handshake; write beats use valid/accept; reads return a valid-strobed stream.
module memory_burst_control #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned LEN_WIDTH    = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  request,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_valid,
    output logic                  write_accept,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  ready,
    output logic                  done,
    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_ISSUE,
        S_READ_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [LEN_WIDTH-1:0]    r_beats_left;
    logic [READ_LATENCY-1:0] r_vpipe;
    logic [DATA_WIDTH-1:0]   r_read_data;
    logic                    r_read_valid;
    logic                    w_beat;
    logic                    w_we;
    logic                    w_accept;
    logic                    w_rd_issue;
    logic                    w_start;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle RAM access decode.
    always_comb begin
        w_next     = r_state;
        w_beat     = 1'b0;
        w_we       = 1'b0;
        w_accept   = 1'b0;
        w_rd_issue = 1'b0;
        w_start    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (request) begin
                    w_start = 1'b1;
                    w_next  = write ? S_WRITE : S_READ_ISSUE;
                end
            end
            S_WRITE: begin
                w_accept = write_valid;
                if (write_valid) begin
                    w_beat = 1'b1;
                    w_we   = 1'b1;
                    if (r_beats_left == '0) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_READ_ISSUE: begin
                w_beat     = 1'b1;
                w_rd_issue = 1'b1;
                if (r_beats_left == '0) begin
                    w_next = S_READ_DRAIN;
                end
            end
            S_READ_DRAIN: begin
                // Last beat is on read_valid now and nothing remains in flight.
                if ((r_vpipe == '0) && r_read_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command fields are latched once and only advanced by performed beats.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cur_addr   <= '0;
            r_beats_left <= '0;
        end else if (w_start) begin
            r_cur_addr   <= address;
            r_beats_left <= length;
        end else if (w_beat) begin
            r_cur_addr   <= r_cur_addr + ADDR_WIDTH'(1);
            r_beats_left <= r_beats_left - LEN_WIDTH'(1);
        end
    end

    // Valid pipe matches RAM latency; its tail marks mem_data_out as a returning beat.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_vpipe      <= '0;
            r_read_valid <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_vpipe[0] <= w_rd_issue;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_read_valid <= r_vpipe[READ_LATENCY-1];
            if (r_vpipe[READ_LATENCY-1]) begin
                r_read_data <= mem_data_out;
            end
        end
    end

    assign ready            = (r_state == S_IDLE);
    assign done             = (r_state == S_DONE);
    assign write_accept     = w_accept;
    assign mem_enable       = w_beat;
    assign mem_write_enable = w_we;
    assign mem_address      = r_cur_addr;
    assign mem_data_in      = write_data;
    assign read_data        = r_read_data;
    assign read_valid       = r_read_valid;

endmodule

// File: tb/tb_memory_burst_control.sv
// Self-checking bench: two instances (read latency 1 and 3) driven in lockstep, each with its own RAM model,
// checked against a reference memory and the command timing rules.
module tb_memory_burst_control;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned LW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          request;
    logic          write;
    logic [AW-1:0] address;
    logic [LW-1:0] length;
    logic [DW-1:0] write_data;
    logic          write_valid;

    logic          wa   [2];
    logic          rv   [2];
    logic          rdy  [2];
    logic          dn   [2];
    logic          men  [2];
    logic          mwe  [2];
    logic [DW-1:0] rd   [2];
    logic [DW-1:0] mdi  [2];
    logic [DW-1:0] mdo  [2];
    logic [AW-1:0] maddr[2];

    logic [DW-1:0] ref_mem [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] ram  [DEPTH];
        logic [DW-1:0] pipe [LAT];

        always @(posedge clock) begin
            if (men[g] && mwe[g]) ram[maddr[g]] <= mdi[g];
            pipe[0] <= ram[maddr[g]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mdo[g] = pipe[LAT-1];

        memory_burst_control #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .LEN_WIDTH   (LW),
            .READ_LATENCY(LAT)
        ) u_dut (
            .clock           (clock),
            .reset_n         (reset_n),
            .request         (request),
            .write           (write),
            .address         (address),
            .length          (length),
            .write_data      (write_data),
            .write_valid     (write_valid),
            .write_accept    (wa[g]),
            .read_data       (rd[g]),
            .read_valid      (rv[g]),
            .ready           (rdy[g]),
            .done            (dn[g]),
            .mem_enable      (men[g]),
            .mem_write_enable(mwe[g]),
            .mem_address     (maddr[g]),
            .mem_data_in     (mdi[g]),
            .mem_data_out    (mdo[g])
        );
    end

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic jitter_cmd_inputs();
        write   = 1'($urandom);
        address = AW'($urandom);
        length  = LW'($urandom);
    endtask

    task automatic do_idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            request     = 1'b0;
            write_valid = 1'($urandom);
            jitter_cmd_inputs();
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                chk("idle_ready", d, 32'(rdy[d]), 32'd1);
                chk("idle_done", d, 32'(dn[d]), 32'd0);
                chk("idle_men", d, 32'(men[d]), 32'd0);
                chk("idle_accept", d, 32'(wa[d]), 32'd0);
                chk("idle_rvalid", d, 32'(rv[d]), 32'd0);
            end
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input int stall_at,
                            input int stall_len, input bit rnd, input bit spam);
        int            beat    = 0;
        int            stalled = 0;
        bit            v;
        logic [DW-1:0] wd;
        logic [AW-1:0] ea;
        @(posedge clock); #1;
        request     = 1'b1;
        write       = 1'b1;
        address     = a;
        length      = LW'(n - 1);
        write_valid = 1'($urandom);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("wr_ready0", d, 32'(rdy[d]), 32'd1);
            chk("wr_accept0", d, 32'(wa[d]), 32'd0);
        end
        while (beat < n) begin
            @(posedge clock); #1;
            if (rnd) v = ($urandom_range(0, 3) != 0);
            else if (beat == stall_at && stalled < stall_len) begin v = 1'b0; stalled++; end
            else v = 1'b1;
            jitter_cmd_inputs();
            request     = spam ? 1'b1 : 1'($urandom);
            wd          = DW'($urandom);
            write_data  = wd;
            write_valid = v;
            ea          = a + AW'(beat);
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                chk("wr_accept", d, 32'(wa[d]), 32'(v));
                chk("wr_men", d, 32'(men[d]), 32'(v));
                chk("wr_mwe", d, 32'(mwe[d]), 32'(v));
                chk("wr_ready", d, 32'(rdy[d]), 32'd0);
                chk("wr_done", d, 32'(dn[d]), 32'd0);
                if (v) begin
                    chk("wr_addr", d, 32'(maddr[d]), 32'(ea));
                    chk("wr_data", d, 32'(mdi[d]), 32'(wd));
                end
            end
            if (v) begin
                ref_mem[ea] = wd;
                beat++;
            end
        end
        @(posedge clock); #1;
        request     = spam;
        write_valid = 1'($urandom);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("wr_done_pulse", d, 32'(dn[d]), 32'd1);
            chk("wr_done_ready", d, 32'(rdy[d]), 32'd0);
            chk("wr_done_accept", d, 32'(wa[d]), 32'd0);
            chk("wr_done_men", d, 32'(men[d]), 32'd0);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int n);
        int            lat;
        int            k;
        bit            ev;
        logic [AW-1:0] ra;
        @(posedge clock); #1;
        request     = 1'b1;
        write       = 1'b0;
        address     = a;
        length      = LW'(n - 1);
        write_valid = 1'($urandom);
        @(negedge clock);
        for (int d = 0; d < 2; d++) chk("rd_ready0", d, 32'(rdy[d]), 32'd1);
        for (int c = 1; c <= n + 6; c++) begin
            @(posedge clock); #1;
            jitter_cmd_inputs();
            request     = (c <= n + 1) ? 1'($urandom) : 1'b0;
            write_valid = 1'($urandom);
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 1 : 3;
                chk("rd_men", d, 32'(men[d]), 32'(c <= n));
                chk("rd_mwe", d, 32'(mwe[d]), 32'd0);
                chk("rd_accept", d, 32'(wa[d]), 32'd0);
                if (c <= n) begin
                    ra = a + AW'(c - 1);
                    chk("rd_addr", d, 32'(maddr[d]), 32'(ra));
                end
                k  = c - lat - 1;
                ev = (k >= 1) && (k <= n);
                chk("rd_valid", d, 32'(rv[d]), 32'(ev));
                if (ev) begin
                    ra = a + AW'(k - 1);
                    chk("rd_data", d, 32'(rd[d]), 32'(ref_mem[ra]));
                end
                chk("rd_done", d, 32'(dn[d]), 32'(c == n + lat + 2));
                chk("rd_ready", d, 32'(rdy[d]), 32'(c >= n + lat + 3));
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        request     = 1'b0;
        write       = 1'b0;
        address     = '0;
        length      = '0;
        write_data  = '0;
        write_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, 32'(rdy[d]), 32'd1);
            chk("rst_done", d, 32'(dn[d]), 32'd0);
            chk("rst_rvalid", d, 32'(rv[d]), 32'd0);
            chk("rst_rdata", d, 32'(rd[d]), 32'd0);
            chk("rst_accept", d, 32'(wa[d]), 32'd0);
            chk("rst_men", d, 32'(men[d]), 32'd0);
            chk("rst_mwe", d, 32'(mwe[d]), 32'd0);
            chk("rst_addr", d, 32'(maddr[d]), 32'd0);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        do_idle(2);

        // Preload the 64-word window 0x3F0..0x02F used by every data check.
        do_write(10'h3F0, 16, -1, 0, 1'b1, 1'b0);
        do_write(10'h000, 16, -1, 0, 1'b1, 1'b0);
        do_write(10'h010, 16, -1, 0, 1'b1, 1'b0);
        do_write(10'h020, 16, -1, 0, 1'b1, 1'b0);

        do_write(10'h005, 1, -1, 0, 1'b0, 1'b0);
        do_read(10'h005, 1);
        do_write(10'h010, 4, 2, 2, 1'b0, 1'b0);
        do_read(10'h010, 4);
        do_read(10'h3FE, 4);
        do_read(10'h020, 2);
        do_write(10'h028, 8, -1, 0, 1'b0, 1'b1);
        do_idle(4);

        // Reset during issue beat 2 of an 8-beat read.
        @(posedge clock); #1;
        request = 1'b1; write = 1'b0; address = 10'h100; length = 4'd7;
        @(negedge clock);
        for (int d = 0; d < 2; d++) chk("abort_ready0", d, 32'(rdy[d]), 32'd1);
        @(posedge clock); #1;
        request = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) chk("abort_beat1", d, 32'(men[d]), 32'd1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("abort_hold_ready", d, 32'(rdy[d]), 32'd1);
            chk("abort_hold_rvalid", d, 32'(rv[d]), 32'd0);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("abort_ready", d, 32'(rdy[d]), 32'd1);
            chk("abort_men", d, 32'(men[d]), 32'd0);
            chk("abort_rvalid", d, 32'(rv[d]), 32'd0);
            chk("abort_done", d, 32'(dn[d]), 32'd0);
            chk("abort_rdata", d, 32'(rd[d]), 32'd0);
        end
        do_idle(6);
        do_write(10'h3F8, 3, -1, 0, 1'b0, 1'b0);
        do_read(10'h3F8, 3);

        for (int t = 0; t < 24; t++) begin
            logic [AW-1:0] ra;
            int            rn;
            ra = AW'(10'h3F0 + AW'($urandom_range(0, 47)));
            rn = $urandom_range(1, 16);
            if ($urandom_range(0, 1) == 1) do_write(ra, rn, -1, 0, 1'b1, 1'b0);
            else                           do_read(ra, rn);
            do_idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
